// File: rtl/esp_uart_rx_flow_bridge.sv
// ESP8266 receive bridge: 8N1 deserializer, FWFT byte FIFO on a valid/ready stream, hardware RTS with hysteresis.
// Optional even-parity check enabled by defining ESP_RX_PARITY_EN.
module esp_uart_rx_flow_bridge #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int RTS_HI_WM   = 12,
  parameter int RTS_LO_WM   = 4
) (
  input  logic                          sysclk,
  input  logic                          sysreset,
  input  logic                          rxd,
  output logic                          rts_n,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_status
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CNTW         = AW + 1;

  localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] HI_C      = CNTW'(RTS_HI_WM);
  localparam logic [CNTW-1:0] LO_C      = CNTW'(RTS_LO_WM);

`ifdef ESP_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic          rx_meta, rxs;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;
`ifdef ESP_RX_PARITY_EN
  logic          par_ok;
`endif

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Push is decoded from the stop-sample cycle so the byte is visible one clock later.
`ifdef ESP_RX_PARITY_EN
  assign push = (state == STOP) && (cnt == '0) && rxs && par_ok;
`else
  assign push = (state == STOP) && (cnt == '0) && rxs;
`endif

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef ESP_RX_PARITY_EN
      par_ok    <= 1'b1;
`endif
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              cnt     <= BIT_LOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= BIT_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef ESP_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef ESP_RX_PARITY_EN
        PARITY: begin
          if (cnt == '0) begin
            par_ok <= ~(^{shreg, rxs});
            cnt    <= BIT_LOAD;
            state  <= STOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop-bit so a following start edge is not missed.
          if (cnt == '0) begin
`ifdef ESP_RX_PARITY_EN
            frame_err <= ~rxs | ~par_ok;
`else
            frame_err <= ~rxs;
`endif
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_nx;
  logic            pop, push_ok;

  assign pop     = m_ready && (count != '0);
  assign push_ok = push && ((count < DEPTH_C) || pop);

  always_comb begin
    count_nx = count;
    case ({push_ok, pop})
      2'b10:   count_nx = count + CNTW'(1);
      2'b01:   count_nx = count - CNTW'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rts_n    <= 1'b1;
    end else begin
      count <= count_nx;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_status)  overflow <= 1'b0;
      if (count_nx >= HI_C)      rts_n <= 1'b1;
      else if (count_nx <= LO_C) rts_n <= 1'b0;
    end
  end

  assign m_valid    = (count != '0);
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_esp_uart_rx_flow_bridge.sv
// Scoreboard bench for esp_uart_rx_flow_bridge at 10 clocks per bit, 16-entry FIFO, watermarks 12/4.
module tb_esp_uart_rx_flow_bridge;

  logic       clk = 1'b0;
  logic       sysreset = 1'b1;
  logic       rxd = 1'b1;
  logic       rdy_d = 1'b0;
  logic       rdy_r = 1'b0;
  logic       rand_en = 1'b0;
  logic       clr_status = 1'b0;
  logic       m_ready;
  logic       rts_n, m_valid, frame_err, overflow;
  logic [7:0] m_data;
  logic [4:0] fifo_count;

  int         total = 0;
  int         bad = 0;
  int         fe_count = 0;
  logic       fe_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic       rts_exp = 1'b1;

  assign m_ready = rand_en ? rdy_r : rdy_d;

  esp_uart_rx_flow_bridge #(
    .CLK_FREQ_HZ(1000000),
    .BAUD(100000),
    .FIFO_DEPTH(16),
    .RTS_HI_WM(12),
    .RTS_LO_WM(4)
  ) dut (
    .sysclk(clk),
    .sysreset(sysreset),
    .rxd(rxd),
    .rts_n(rts_n),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_count(fifo_count),
    .frame_err(frame_err),
    .overflow(overflow),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rdy_r = ($urandom_range(0, 1) == 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!sysreset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got data %0h required no pop", m_data);
      end else begin
        check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
    if (!sysreset && frame_err) begin
      fe_count++;
      check("frame_err_width", 32'(fe_prev), 32'(0));
    end
    fe_prev = frame_err;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1 rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(posedge clk);
      #1 rxd = d[i];
    end
    repeat (10) @(posedge clk); #1 rxd = stop;
    repeat (10) @(posedge clk); #1 rxd = 1'b1;
  endtask

  function automatic logic rts_model(input int n, input logic prev);
    if (n >= 12) return 1'b1;
    if (n <= 4)  return 1'b0;
    return prev;
  endfunction

  task automatic drain(input string name);
    @(posedge clk); #1 rdy_d = 1'b1;
    for (int i = 0; i < 100 && fifo_count != 0; i++) @(negedge clk);
    check(name, 32'(fifo_count), 32'(0));
    check({name, "_queue"}, 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1 rdy_d = 1'b0;
    rts_exp = 1'b0;
  endtask

  task automatic pop_one();
    @(posedge clk); #1 rdy_d = 1'b1;
    @(posedge clk); #1 rdy_d = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rts_n"}, 32'(rts_n), 32'(1));
    check({tag, "_m_valid"}, 32'(m_valid), 32'(0));
    check({tag, "_m_data"}, 32'(m_data), 32'(0));
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'(0));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(0));
    check({tag, "_overflow"}, 32'(overflow), 32'(0));
  endtask

  initial begin
    logic [7:0] b;
    logic       stp;
    logic       ov_exp;
    int         fe0;
    int         fe_exp;

    // Reset values and RTS release timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1 sysreset = 1'b0;
    @(negedge clk);
    check("rts_before_first_clk", 32'(rts_n), 32'(1));
    @(negedge clk);
    check("rts_after_first_clk", 32'(rts_n), 32'(0));
    rts_exp = 1'b0;

    // 0xA5: byte appears one clock after the stop sample (start edge + 3 + 5 + 9*10 clocks)
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (97) @(posedge clk);
        @(negedge clk);
        check("a5_valid_before", 32'(m_valid), 32'(0));
        @(negedge clk);
        check("a5_valid_after", 32'(m_valid), 32'(1));
        check("a5_head", 32'(m_data), 32'(8'hA5));
      end
    join
    check("a5_count", 32'(fifo_count), 32'(1));
    drain("a5_drain");

    // Start-bit glitch of 3 clocks
    fe0 = fe_count;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_frame_err", 32'(fe_count), 32'(fe0));
    check("glitch_count", 32'(fifo_count), 32'(0));

    // Bad stop bit
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("stop_err_pulses", 32'(fe_count), 32'(fe0 + 1));
    check("stop_err_count", 32'(fifo_count), 32'(0));

    // Receiver still healthy after glitch and framing error
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    drain("recover_drain");

    // RTS hysteresis: fill to 12, pop down to 4
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      @(negedge clk);
      rts_exp = rts_model(exp_q.size(), rts_exp);
      check("wm_fill_count", 32'(fifo_count), 32'(exp_q.size()));
      check("wm_fill_rts", 32'(rts_n), 32'(rts_exp));
    end
    while (exp_q.size() > 4) begin
      pop_one();
      rts_exp = rts_model(exp_q.size(), rts_exp);
      check("wm_pop_count", 32'(fifo_count), 32'(exp_q.size()));
      check("wm_pop_rts", 32'(rts_n), 32'(rts_exp));
    end
    drain("wm_drain");

    // Overflow with 17 bytes and no consumer
    ov_exp = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (exp_q.size() < 16) exp_q.push_back(b);
      else ov_exp = 1'b1;
      send_frame(b, 1'b1);
    end
    @(negedge clk);
    rts_exp = rts_model(exp_q.size(), rts_exp);
    check("ovf_count", 32'(fifo_count), 32'(exp_q.size()));
    check("ovf_flag", 32'(overflow), 32'(ov_exp));
    check("ovf_head", 32'(m_data), 32'(exp_q[0]));
    check("ovf_rts", 32'(rts_n), 32'(rts_exp));
    @(posedge clk); #1 clr_status = 1'b1;
    @(posedge clk); #1 clr_status = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'(0));
    drain("ovf_drain");

    // Reset in the middle of the data bits with a byte already queued
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    fe0 = fe_count;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (10) @(posedge clk); #1 rxd = 1'b1;
    repeat (10) @(posedge clk); #1 rxd = 1'b0;
    repeat (15) @(posedge clk); #1 begin sysreset = 1'b1; rxd = 1'b1; end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1 sysreset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_rts_release", 32'(rts_n), 32'(0));
    check("midrst_no_err", 32'(fe_count), 32'(fe0));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    @(negedge clk);
    check("post_rst_count", 32'(fifo_count), 32'(1));
    drain("post_rst_drain");

    // Random frames, random stop-bit errors, random consumer
    fe0 = fe_count;
    fe_exp = 0;
    rand_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      stp = ($urandom_range(0, 9) != 0);
      if (stp) exp_q.push_back(b);
      else fe_exp++;
      send_frame(b, stp);
      if (stp) repeat ($urandom_range(0, 15)) @(posedge clk);
      else repeat ($urandom_range(10, 25)) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #1 rand_en = 1'b0;
    drain("rand_drain");
    check("rand_frame_errs", 32'(fe_count), 32'(fe0 + fe_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
